// File: rtl/cmd_host_if.sv
// Command/UART bus for cmd_host. The master side is user logic plus the UART.
// The slave side is cmd_host itself.
interface cmd_host_if;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic [7:0]  i_cmd;
  logic [63:0] i_cmd_data;
  logic        o_resp_valid;
  logic [63:0] o_resp_data;
  logic        o_resp_err;
  logic        o_timeout;
  logic        o_tx_start;
  logic [7:0]  o_tx_data;
  logic        i_tx_done;
  logic [7:0]  i_rx_data;
  logic        i_rx_new;
  logic        i_rx_err;

  modport master (
    output i_cmd_valid, i_cmd, i_cmd_data, i_tx_done, i_rx_data, i_rx_new, i_rx_err,
    input  o_cmd_ready, o_resp_valid, o_resp_data, o_resp_err, o_timeout,
           o_tx_start, o_tx_data
  );

  modport slave (
    input  i_cmd_valid, i_cmd, i_cmd_data, i_tx_done, i_rx_data, i_rx_new, i_rx_err,
    output o_cmd_ready, o_resp_valid, o_resp_data, o_resp_err, o_timeout,
           o_tx_start, o_tx_data
  );
endinterface

// File: rtl/cmd_host.sv
// cmd_host: sends a 9-byte command frame (opcode, then payload LSB first) over a
// byte UART. It then collects an 8-byte response frame, LSB first.
// Optional feature macro CMD_HOST_TIMEOUT_EN adds a response inactivity timeout.
// The timeout limit is p_timeout_cycles.
module cmd_host #(
  parameter int p_timeout_cycles = 1000000
) (
  input logic      i_clk,
  input logic      i_rst,
  cmd_host_if.slave bus
);

  typedef enum logic [2:0] {IDLE, TX_START, TX_WAIT, RX, DONE} state_t;

  state_t      state, nxt;
  logic [3:0]  idx;        // tx byte index 0..8, then rx byte index 0..7
  logic [63:0] payload;    // remaining payload bytes, shifted down as they go out
  logic [7:0]  tx_data;
  logic [63:0] resp_data;
  logic        resp_err;
  logic        resp_tmo;
  logic        tmo_hit;

`ifdef CMD_HOST_TIMEOUT_EN
  localparam int CW = (p_timeout_cycles > 2) ? $clog2(p_timeout_cycles) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(p_timeout_cycles - 1);
  logic [CW-1:0] tmo_cnt;

  // Any received byte counts as activity, so it suppresses a same-cycle expiry.
  assign tmo_hit = (state == RX) && (tmo_cnt == TMO_LAST) && !bus.i_rx_new;

  // Inactivity counter: zeroed on RX entry and on every received byte.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      tmo_cnt  <= '0;
      resp_tmo <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (bus.i_cmd_valid) resp_tmo <= 1'b0;
        TX_WAIT: tmo_cnt <= '0;
        RX: begin
          tmo_cnt <= bus.i_rx_new ? '0 : tmo_cnt + 1'b1;
          if (tmo_hit) resp_tmo <= 1'b1;
        end
        default: ;
      endcase
    end
  end
`else
  assign tmo_hit  = 1'b0;
  assign resp_tmo = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= IDLE;
    else        state <= nxt;
  end

  // Next-state logic. An error or a timeout ends RX at once.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (bus.i_cmd_valid) nxt = TX_START;
      TX_START: nxt = TX_WAIT;
      TX_WAIT:  if (bus.i_tx_done) nxt = (idx == 4'd8) ? RX : TX_START;
      RX:       if (bus.i_rx_err || tmo_hit || (bus.i_rx_new && idx == 4'd7)) nxt = DONE;
      DONE:     nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  // State-decoded handshake outputs.
  always_comb begin
    bus.o_cmd_ready  = (state == IDLE);
    bus.o_tx_start   = (state == TX_START);
    bus.o_resp_valid = (state == DONE);
  end

  // Datapath: latch the command, step through tx bytes, and assemble the response.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      idx       <= '0;
      payload   <= '0;
      tx_data   <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.i_cmd_valid) begin
          tx_data   <= bus.i_cmd;
          payload   <= bus.i_cmd_data;
          idx       <= '0;
          resp_data <= '0;
          resp_err  <= 1'b0;
        end
        TX_WAIT: if (bus.i_tx_done) begin
          if (idx == 4'd8) idx <= '0;
          else begin
            idx     <= idx + 4'd1;
            tx_data <= payload[7:0];
            payload <= payload >> 8;
          end
        end
        RX: begin
          // An error wins over a same-cycle byte, and that byte is dropped.
          if (bus.i_rx_err) resp_err <= 1'b1;
          else if (bus.i_rx_new) begin
            resp_data[{idx[2:0], 3'b000} +: 8] <= bus.i_rx_data;
            idx <= idx + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_tx_data   = tx_data;
  assign bus.o_resp_data = resp_data;
  assign bus.o_resp_err  = resp_err;
  assign bus.o_timeout   = resp_tmo;

endmodule

// File: tb/tb_cmd_host.sv
// Randomized bench for cmd_host. The reference model builds the expected tx
// frame and response word directly from the frame format.
module tb_cmd_host;
  localparam int TMO = 100;
`ifdef CMD_HOST_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  cmd_host_if bus();

  cmd_host #(.p_timeout_cycles(TMO)) dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus.slave));

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_cmd_valid = 1'b0; bus.i_cmd = '0; bus.i_cmd_data = '0;
    bus.i_tx_done = 1'b0; bus.i_rx_data = '0; bus.i_rx_new = 1'b0; bus.i_rx_err = 1'b0;
  endtask

  // Send one command. gap=0 means a random tx latency. Stop after the start of
  // byte stop_at (9 = complete frame).
  task automatic tx_phase(input logic [7:0] op, input logic [63:0] d, input int gap,
                          input bit junk, input int stop_at);
    logic [7:0] fr [9];
    int n;
    fr[0] = op;
    for (int k = 1; k < 9; k++) fr[k] = d[8*(k-1) +: 8];
    chk("ready_idle", bus.o_cmd_ready, 1'b1);
    bus.i_cmd_valid = 1'b1; bus.i_cmd = op; bus.i_cmd_data = d;
    tick();
    bus.i_cmd_valid = 1'b0;
    chk("acc_clr_data", bus.o_resp_data, 64'd0);
    chk("acc_clr_err", bus.o_resp_err, 1'b0);
    chk("acc_clr_tmo", bus.o_timeout, 1'b0);
    for (int k = 0; k < 9; k++) begin
      chk("tx_start", bus.o_tx_start, 1'b1);
      chk("tx_byte", bus.o_tx_data, fr[k]);
      if (k == stop_at) return;
      n = (gap > 0) ? gap : $urandom_range(1, 6);
      for (int j = 0; j < n; j++) begin
        tick();
        chk("tx_start_once", bus.o_tx_start, 1'b0);
        chk("tx_hold", bus.o_tx_data, fr[k]);
        chk("busy_not_ready", bus.o_cmd_ready, 1'b0);
        // Traffic that must be ignored while transmitting.
        bus.i_rx_new    = junk & $urandom_range(0, 1);
        bus.i_rx_err    = junk & ($urandom_range(0, 3) == 0);
        bus.i_rx_data   = 8'($urandom);
        bus.i_cmd_valid = junk & $urandom_range(0, 1);
        bus.i_cmd       = 8'($urandom);
        bus.i_cmd_data  = {$urandom, $urandom};
      end
      idle_inputs();
      bus.i_tx_done = 1'b1;
      tick();
      bus.i_tx_done = 1'b0;
    end
  endtask

  // Response phase: deliver nbytes bytes from rb, then optionally an error.
  // When both is set, the error is sent with a discarded byte.
  task automatic rx_phase(input logic [63:0] rb, input int nbytes, input bit do_err,
                          input bit both);
    logic [63:0] exp = '0;
    int g;
    for (int i = 0; i < nbytes; i++) begin
      g = $urandom_range(0, 4);
      for (int j = 0; j < g; j++) begin
        tick();
        chk("rx_gap_novalid", bus.o_resp_valid, 1'b0);
      end
      bus.i_rx_new = 1'b1; bus.i_rx_data = rb[8*i +: 8];
      exp[8*i +: 8] = rb[8*i +: 8];
      tick();
      bus.i_rx_new = 1'b0;
      if (i < 7) chk("rx_mid_novalid", bus.o_resp_valid, 1'b0);
    end
    if (do_err) begin
      bus.i_rx_err = 1'b1; bus.i_rx_new = both; bus.i_rx_data = 8'($urandom);
      tick();
      bus.i_rx_err = 1'b0; bus.i_rx_new = 1'b0;
    end
    chk("resp_valid", bus.o_resp_valid, 1'b1);
    chk("resp_data", bus.o_resp_data, exp);
    chk("resp_err", bus.o_resp_err, do_err);
    chk("resp_tmo", bus.o_timeout, 1'b0);
    tick();
    chk("resp_pulse", bus.o_resp_valid, 1'b0);
    chk("ready_after", bus.o_cmd_ready, 1'b1);
    chk("resp_held", bus.o_resp_data, exp);
  endtask

  initial begin
    int cnt, nb;
    bit seen;
    idle_inputs();
    repeat (3) tick();
    chk("rst_tx_start", bus.o_tx_start, 1'b0);
    chk("rst_resp_valid", bus.o_resp_valid, 1'b0);
    i_rst = 1'b1;
    tick();
    chk("rst_ready", bus.o_cmd_ready, 1'b1);
    chk("rst_valid", bus.o_resp_valid, 1'b0);
    chk("rst_data", bus.o_resp_data, 64'd0);
    chk("rst_err", bus.o_resp_err, 1'b0);
    chk("rst_tmo", bus.o_timeout, 1'b0);
    chk("rst_start", bus.o_tx_start, 1'b0);
    chk("rst_txdata", bus.o_tx_data, 8'd0);

    // Directed frames.
    tx_phase(8'h70, 64'h0123456789ABCDEF, 20, 1'b0, 9);
    rx_phase(64'h8877665544332211, 8, 1'b0, 1'b0);
    tx_phase(8'h70, 64'h0123456789ABCDEF, 0, 1'b1, 9);
    rx_phase(64'h0000000000CCBBAA, 3, 1'b1, 1'b0);
    tx_phase(8'h5A, 64'hFFFF_0000_A5A5_1234, 0, 1'b0, 9);
    rx_phase(64'h0000_0000_0000_0099, 1, 1'b1, 1'b1);

    // No response: a timeout when enabled, otherwise an indefinite wait.
    tx_phase(8'h33, 64'h1122334455667788, 0, 1'b0, 9);
    if (TMO_EN) begin
      cnt = 0;
      while (!bus.o_resp_valid && cnt < TMO + 50) begin tick(); cnt++; end
      chk("tmo_latency", cnt, TMO);
      chk("tmo_flag", bus.o_timeout, 1'b1);
      chk("tmo_err", bus.o_resp_err, 1'b0);
      chk("tmo_data", bus.o_resp_data, 64'd0);
      tick();
      chk("tmo_pulse", bus.o_resp_valid, 1'b0);
    end else begin
      seen = 1'b0;
      for (int i = 0; i < 10000; i++) begin tick(); seen |= bus.o_resp_valid; end
      chk("no_tmo_pulse", seen, 1'b0);
      rx_phase(64'd0, 0, 1'b1, 1'b0);
    end

    // Error arrives in the same cycle as the timeout expiry.
    tx_phase(8'h44, 64'hCAFEF00DDEADBEEF, 0, 1'b0, 9);
    repeat (TMO - 1) tick();
    chk("pre_hit_novalid", bus.o_resp_valid, 1'b0);
    bus.i_rx_err = 1'b1;
    tick();
    bus.i_rx_err = 1'b0;
    chk("hit_valid", bus.o_resp_valid, 1'b1);
    chk("hit_err", bus.o_resp_err, 1'b1);
    chk("hit_tmo", bus.o_timeout, TMO_EN);
    tick();

    // Reset while the 4th byte is in flight.
    tx_phase(8'hC3, 64'h0807060504030201, 0, 1'b0, 3);
    tick(); tick();
    #2 i_rst = 1'b0;
    #1;
    chk("arst_start", bus.o_tx_start, 1'b0);
    chk("arst_valid", bus.o_resp_valid, 1'b0);
    tick(); tick();
    i_rst = 1'b1;
    tick();
    chk("arst_ready", bus.o_cmd_ready, 1'b1);
    chk("arst_txdata", bus.o_tx_data, 8'd0);
    chk("arst_data", bus.o_resp_data, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      seen |= bus.o_resp_valid | bus.o_tx_start;
    end
    chk("arst_quiet", seen, 1'b0);

    // Random transactions.
    for (int t = 0; t < 20; t++) begin
      nb = $urandom_range(0, 8);
      tx_phase(8'($urandom), {$urandom, $urandom}, 0, 1'b1, 9);
      rx_phase({$urandom, $urandom}, nb, nb < 8, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cmd_host.md
CMD_HOST -- requirements
Module: cmd_host

Interface
REQ-001 Parameter p_timeout_cycles, default 1000000, response inactivity limit in i_clk cycles (≥2).
REQ-002 i_clk  input  1  single clock; all logic on rising edge.
REQ-003 i_rst  input  1  asynchronous, active-low reset.
REQ-004 i_cmd_valid  input  1  command request from user logic.
REQ-005 o_cmd_ready  output  1  high only in IDLE; request accepted when i_cmd_valid & o_cmd_ready.
REQ-006 i_cmd  input  8  opcode byte.
REQ-007 i_cmd_data  input  64  command payload.
REQ-008 o_resp_valid  output  1  one-cycle pulse: transaction finished.
REQ-009 o_resp_data  output  64  assembled response, held until next acceptance.
REQ-010 o_resp_err  output  1  qualifies o_resp_valid: UART framing error during response.
REQ-011 o_timeout  output  1  qualifies o_resp_valid: response inactivity timeout.
REQ-012 o_tx_start  output  1  one-cycle pulse to UART transmitter.
REQ-013 o_tx_data  output  8  byte to transmit, valid with o_tx_start, held until i_tx_done.
REQ-014 i_tx_done  input  1  one-cycle pulse: UART finished current byte.
REQ-015 i_rx_data  input  8  received byte, valid with i_rx_new.
REQ-016 i_rx_new  input  1  one-cycle pulse: new received byte.
REQ-017 i_rx_err  input  1  one-cycle pulse: receive framing error.

Function
REQ-018 Command frame SHALL be 9 bytes: opcode, then i_cmd_data bytes [7:0] first through [63:56] last.
REQ-019 Response frame SHALL be 8 bytes, first received byte into o_resp_data[7:0], eighth into [63:56].
REQ-020 States SHALL be IDLE, TX_START, TX_WAIT, RX, DONE.
REQ-021 IDLE: on acceptance latch i_cmd/i_cmd_data, clear byte index and o_resp_data, go TX_START.
REQ-022 TX_START: assert o_tx_start for exactly one cycle with current byte, go TX_WAIT.
REQ-023 TX_WAIT: on i_tx_done, if 9 bytes sent go RX, else increment index and go TX_START (next start exactly one cycle after i_tx_done).
REQ-024 i_rx_new/i_rx_err in IDLE, TX_START, TX_WAIT SHALL be ignored.
REQ-025 RX: each i_rx_new stores i_rx_data at byte index; after the eighth byte go DONE.
REQ-026 RX: i_rx_err SHALL set o_resp_err and go DONE immediately; partial data retained.
REQ-027 DONE: assert o_resp_valid one cycle with qualifiers, go IDLE; o_cmd_ready high the following cycle.
REQ-028 Simultaneous i_rx_new and i_rx_err in RX: error takes precedence, byte discarded.
REQ-029 o_resp_err/o_timeout SHALL clear on next command acceptance.
REQ-030 i_cmd_valid outside IDLE SHALL have no effect.

Reset
REQ-031 Assertion of i_rst SHALL force IDLE immediately, aborting any transaction with no o_resp_valid.
REQ-032 Reset values: o_cmd_ready 1 after deassertion, o_resp_valid 0, o_resp_data 0, o_resp_err 0, o_timeout 0, o_tx_start 0, o_tx_data 0.

Configuration
REQ-033 Macro CMD_HOST_TIMEOUT_EN defined: counter cleared on RX entry and on each i_rx_new; reaching p_timeout_cycles in RX sets o_timeout and goes DONE.
REQ-034 Macro CMD_HOST_TIMEOUT_EN undefined: no counter, o_timeout constant 0, RX waits indefinitely.
REQ-035 i_rx_err and timeout in same cycle: o_resp_err and o_timeout both set.

Verification
REQ-036 Cmd 0x70, data 0x0123456789ABCDEF, tx_done 20 cycles after each start -> tx bytes 70 EF CD AB 89 67 45 23 01, each start one cycle after prior done.
REQ-037 Response bytes 11 22 33 44 55 66 77 88 -> o_resp_valid one cycle, o_resp_data 0x8877665544332211, err/timeout 0.
REQ-038 i_rx_err after 3 response bytes AA BB CC -> o_resp_valid, o_resp_err 1, o_resp_data 0x0000000000CCBBAA.
REQ-039 CMD_HOST_TIMEOUT_EN, p_timeout_cycles 100, no response -> o_resp_valid with o_timeout 1 exactly 100 cycles after RX entry; undefined -> no pulse in 10000 cycles.
REQ-040 i_rst low during 4th tx byte -> o_tx_start 0, o_cmd_ready 1 after release, no o_resp_valid; i_rx_new during TX_WAIT -> byte not stored.
